i2c_slv_l2_writer: RTL and testbench

Byte-to-word write engine between the PMS I2C slave receiver and the L2 memory port. It takes the framed byte stream the slave delivers after an address match (start, data bytes, stop), packs the bytes little-endian into 32-bit words, and issues word writes to consecutive L2 addresses from a fixed base. It also reports byte count, overflow and completion, so software can dump and check the received region.

---
 rtl/i2c_slv_l2_writer_if.sv | 40 ++++
 rtl/i2c_slv_l2_writer.sv | 172 +++++++++++++++++
 tb/tb_i2c_slv_l2_writer.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slv_l2_writer_if.sv
// rtl/i2c_slv_l2_writer_if.sv - receive stream, L2 write port and status bundle of the I2C slave L2 writer

interface i2c_slv_l2_writer_if #(
    parameter int CNT_WIDTH = 16
);
    // framed byte stream from the I2C slave receiver
    logic                 rx_start_i;
    logic                 rx_stop_i;
    logic                 rx_valid_i;
    logic [7:0]           rx_data_i;
    logic                 rx_ready_o;

    // L2 memory write port
    logic                 mem_req_o;
    logic                 mem_gnt_i;
    logic                 mem_we_o;
    logic [3:0]           mem_be_o;
    logic [31:0]          mem_addr_o;
    logic [31:0]          mem_wdata_o;

    // transfer status
    logic                 busy_o;
    logic                 done_o;
    logic [CNT_WIDTH-1:0] byte_cnt_o;
    logic                 overflow_o;

    // writer side
    modport slave (
        input  rx_start_i, rx_stop_i, rx_valid_i, rx_data_i, mem_gnt_i,
        output rx_ready_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output busy_o, done_o, byte_cnt_o, overflow_o
    );

    // environment side: byte source, memory and status observer
    modport master (
        output rx_start_i, rx_stop_i, rx_valid_i, rx_data_i, mem_gnt_i,
        input  rx_ready_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  busy_o, done_o, byte_cnt_o, overflow_o
    );
endinterface

// File: rtl/i2c_slv_l2_writer.sv
// rtl/i2c_slv_l2_writer.sv - packs I2C slave bytes little-endian into 32-bit L2 word writes

module i2c_slv_l2_writer #(
    parameter logic [31:0] BASE_ADDR = 32'h1C01_0000,
    parameter int          MAX_BYTES = 4096,
    parameter int          CNT_WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    i2c_slv_l2_writer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_BYTES);

    state_t               state, state_nxt;
    logic [1:0]           lane, lane_nxt;
    logic [3:0]           be, be_nxt;
    logic [31:0]          wdata, wdata_nxt;
    logic [31:0]          addr, addr_nxt;
    logic [CNT_WIDTH-1:0] byte_cnt, byte_cnt_nxt;
    logic                 overflow, overflow_nxt;
    logic                 stop_pend, stop_pend_nxt;
    logic                 start_pend, start_pend_nxt;

    logic                 frame_end;
    logic                 store;
    logic                 start_xfer;

    // A repeated start closes the current frame exactly like a stop does.
    assign frame_end = bus.rx_stop_i | bus.rx_start_i;

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            lane       <= 2'd0;
            be         <= 4'b0000;
            wdata      <= 32'h0;
            addr       <= BASE_ADDR;
            byte_cnt   <= '0;
            overflow   <= 1'b0;
            stop_pend  <= 1'b0;
            start_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            lane       <= lane_nxt;
            be         <= be_nxt;
            wdata      <= wdata_nxt;
            addr       <= addr_nxt;
            byte_cnt   <= byte_cnt_nxt;
            overflow   <= overflow_nxt;
            stop_pend  <= stop_pend_nxt;
            start_pend <= start_pend_nxt;
        end
    end

    // Next-state and datapath update; byte intake is applied before stop/start handling.
    always_comb begin
        state_nxt      = state;
        lane_nxt       = lane;
        be_nxt         = be;
        wdata_nxt      = wdata;
        addr_nxt       = addr;
        byte_cnt_nxt   = byte_cnt;
        overflow_nxt   = overflow;
        stop_pend_nxt  = stop_pend;
        start_pend_nxt = start_pend;
        store          = 1'b0;
        start_xfer     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.rx_start_i) begin
                    start_xfer = 1'b1;
                    state_nxt  = COLLECT;
                end
            end

            COLLECT: begin
                // Once the byte budget is used up, bytes are still taken so the bus keeps
                // moving, but they are dropped and flagged.
                store = bus.rx_valid_i && (byte_cnt != MAX_CNT);
                if (bus.rx_valid_i && !store) begin
                    overflow_nxt = 1'b1;
                end
                if (store) begin
                    wdata_nxt[{lane, 3'b000} +: 8] = bus.rx_data_i;
                    be_nxt[lane]                   = 1'b1;
                    lane_nxt                       = lane + 2'd1;
                    byte_cnt_nxt                   = byte_cnt + 1'b1;
                end
                if (bus.rx_start_i) begin
                    start_pend_nxt = 1'b1;
                end
                if (store && (lane == 2'd3)) begin
                    state_nxt = WRITE;
                    if (frame_end) begin
                        stop_pend_nxt = 1'b1;
                    end
                end else if (frame_end) begin
                    if (be_nxt != 4'b0000) begin
                        state_nxt     = WRITE;
                        stop_pend_nxt = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end

            WRITE: begin
                if (frame_end) begin
                    stop_pend_nxt = 1'b1;
                end
                if (bus.rx_start_i) begin
                    start_pend_nxt = 1'b1;
                end
                if (bus.mem_gnt_i) begin
                    addr_nxt  = addr + 32'd4;
                    lane_nxt  = 2'd0;
                    be_nxt    = 4'b0000;
                    wdata_nxt = 32'h0;
                    state_nxt = (stop_pend || frame_end) ? DONE : COLLECT;
                end
            end

            DONE: begin
                stop_pend_nxt  = 1'b0;
                start_pend_nxt = 1'b0;
                if (start_pend || bus.rx_start_i) begin
                    start_xfer = 1'b1;
                    state_nxt  = COLLECT;
                end else begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Fresh transfer: rewind to the base address and clear the per-transfer status.
        if (start_xfer) begin
            lane_nxt     = 2'd0;
            be_nxt       = 4'b0000;
            wdata_nxt    = 32'h0;
            addr_nxt     = BASE_ADDR;
            byte_cnt_nxt = '0;
            overflow_nxt = 1'b0;
        end
    end

    // Bus outputs are held at zero outside WRITE so the idle port is quiet.
    assign bus.rx_ready_o  = (state == COLLECT);
    assign bus.mem_req_o   = (state == WRITE);
    assign bus.mem_we_o    = (state == WRITE);
    assign bus.mem_be_o    = (state == WRITE) ? be : 4'b0000;
    assign bus.mem_addr_o  = (state == WRITE) ? addr : 32'h0;
    assign bus.mem_wdata_o = (state == WRITE) ? wdata : 32'h0;
    assign bus.busy_o      = (state != IDLE);
    assign bus.done_o      = (state == DONE);
    assign bus.byte_cnt_o  = byte_cnt;
    assign bus.overflow_o  = overflow;

endmodule

// File: tb/tb_i2c_slv_l2_writer.sv
// tb/tb_i2c_slv_l2_writer.sv - self-checking bench for the I2C slave L2 writer

module tb_i2c_slv_l2_writer;

    localparam logic [31:0] BASE = 32'h1C01_0000;
    localparam int          MAXB = 8;
    localparam int          CW   = 16;

    logic clk = 1'b0;
    logic rst;

    i2c_slv_l2_writer_if #(.CNT_WIDTH(CW)) bus ();

    i2c_slv_l2_writer #(
        .BASE_ADDR (BASE),
        .MAX_BYTES (MAXB),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model of the expected L2 image for the current transfer
    logic [7:0]  m_buf[$];
    int          m_n;
    int          m_words;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [3:0]  exp_be_q[$];
    int          done_cnt_q[$];
    bit          done_ovf_q[$];

    // observed writes
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [3:0]  log_be[$];

    int   gnt_delay = 0;
    int   wait_cnt  = 0;
    int   cyc       = 0;
    int   dut_done  = 0;
    int   gnt_cyc   = 0;
    int   done_cyc  = 0;
    int   stall     = 0;
    int   last_stall = 0;

    logic        p_req  = 1'b0;
    logic        p_gnt  = 1'b0;
    logic        p_rst  = 1'b1;
    logic        p_done = 1'b0;
    logic [31:0] p_addr  = 32'h0;
    logic [31:0] p_wdata = 32'h0;
    logic [3:0]  p_be    = 4'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_start();
        m_n     = 0;
        m_words = 0;
        m_buf.delete();
    endtask

    task automatic model_flush();
        logic [31:0] d = 32'h0;
        logic [3:0]  b = 4'h0;
        for (int i = 0; i < m_buf.size(); i++) begin
            d[8*i +: 8] = m_buf[i];
            b[i]        = 1'b1;
        end
        exp_addr_q.push_back(BASE + 32'(4 * m_words));
        exp_data_q.push_back(d);
        exp_be_q.push_back(b);
        m_words++;
        m_buf.delete();
    endtask

    task automatic model_byte(input logic [7:0] d);
        if (m_n < MAXB) begin
            m_buf.push_back(d);
            if (m_buf.size() == 4) model_flush();
        end
        m_n++;
    endtask

    task automatic model_end();
        if (m_buf.size() > 0) model_flush();
        done_cnt_q.push_back((m_n < MAXB) ? m_n : MAXB);
        done_ovf_q.push_back(m_n > MAXB);
    endtask

    // memory grant responder: grant after gnt_delay stalled cycles
    initial begin
        bus.mem_gnt_i = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (bus.mem_req_o && !rst) begin
                bus.mem_gnt_i = (wait_cnt >= gnt_delay);
                wait_cnt++;
            end else begin
                bus.mem_gnt_i = 1'b0;
                wait_cnt      = 0;
            end
        end
    end

    // per-cycle compare against the model and the port rules
    initial begin
        forever begin
            @(negedge clk); #2;
            cyc++;
            if (rst) begin
                stall = 0;
            end else begin
                check("we_follows_req", bus.mem_we_o, bus.mem_req_o);
                if (bus.mem_req_o) check("ready_low_in_write", bus.rx_ready_o, 1'b0);
                if (bus.mem_req_o || bus.rx_ready_o || bus.done_o) check("busy_high", bus.busy_o, 1'b1);
                if (p_req && !p_gnt && !p_rst) begin
                    check("req_held", bus.mem_req_o, 1'b1);
                    check("addr_stable", bus.mem_addr_o, p_addr);
                    check("wdata_stable", bus.mem_wdata_o, p_wdata);
                    check("be_stable", bus.mem_be_o, p_be);
                end
                if (bus.mem_req_o && !bus.mem_gnt_i) stall++;
                if (bus.mem_req_o && bus.mem_gnt_i) begin
                    last_stall = stall;
                    stall      = 0;
                    gnt_cyc    = cyc;
                    log_addr.push_back(bus.mem_addr_o);
                    log_data.push_back(bus.mem_wdata_o);
                    log_be.push_back(bus.mem_be_o);
                    check("write_expected", exp_addr_q.size() > 0, 1'b1);
                    if (exp_addr_q.size() > 0) begin
                        check("wr_addr", bus.mem_addr_o, exp_addr_q.pop_front());
                        check("wr_data", bus.mem_wdata_o, exp_data_q.pop_front());
                        check("wr_be", bus.mem_be_o, exp_be_q.pop_front());
                    end
                end
                if (bus.done_o) begin
                    dut_done++;
                    done_cyc = cyc;
                    check("done_single", p_done, 1'b0);
                    check("writes_drained_at_done", exp_addr_q.size(), 0);
                    check("done_expected", done_cnt_q.size() > 0, 1'b1);
                    if (done_cnt_q.size() > 0) begin
                        check("done_byte_cnt", bus.byte_cnt_o, done_cnt_q.pop_front());
                        check("done_overflow", bus.overflow_o, done_ovf_q.pop_front());
                    end
                end
            end
            p_req   = bus.mem_req_o;
            p_gnt   = bus.mem_gnt_i;
            p_rst   = rst;
            p_done  = bus.done_o;
            p_addr  = bus.mem_addr_o;
            p_wdata = bus.mem_wdata_o;
            p_be    = bus.mem_be_o;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic pulse_start();
        bus.rx_start_i = 1'b1;
        step();
        bus.rx_start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.rx_stop_i = 1'b1;
        step();
        bus.rx_stop_i = 1'b0;
    endtask

    task automatic begin_frame();
        model_start();
        pulse_start();
    endtask

    task automatic end_frame();
        model_end();
        pulse_stop();
    endtask

    task automatic send_byte(input logic [7:0] d);
        int guard = 0;
        model_byte(d);
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = d;
        while (!bus.rx_ready_o && guard < 200) begin
            step();
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_byte_timeout: got ready=0 expected ready=1 for byte %0h", d);
        end
        step();
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int guard = 0;
        while (dut_done < target && guard < 300) begin
            step();
            guard++;
        end
        check("done_seen", dut_done, target);
        step();
    endtask

    task automatic log_clear();
        log_addr.delete();
        log_data.delete();
        log_be.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rx_ready"}, bus.rx_ready_o, 1'b0);
        check({tag, "_mem_req"}, bus.mem_req_o, 1'b0);
        check({tag, "_mem_we"}, bus.mem_we_o, 1'b0);
        check({tag, "_mem_be"}, bus.mem_be_o, 4'h0);
        check({tag, "_mem_addr"}, bus.mem_addr_o, 32'h0);
        check({tag, "_mem_wdata"}, bus.mem_wdata_o, 32'h0);
        check({tag, "_busy"}, bus.busy_o, 1'b0);
        check({tag, "_done"}, bus.done_o, 1'b0);
        check({tag, "_byte_cnt"}, bus.byte_cnt_o, 16'h0);
        check({tag, "_overflow"}, bus.overflow_o, 1'b0);
    endtask

    initial begin
        int nd = 0;
        int done_before;
        rst            = 1'b1;
        bus.rx_start_i = 1'b0;
        bus.rx_stop_i  = 1'b0;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        step(3);
        check_zero("reset");
        rst = 1'b0;
        step(2);

        // eight bytes, two full words
        log_clear();
        begin_frame();
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        end_frame();
        wait_done(++nd);
        check("t1_nwrites", log_addr.size(), 2);
        check("t1_w0_addr", log_addr[0], BASE);
        check("t1_w0_data", log_data[0], 32'h0403_0201);
        check("t1_w0_be", log_be[0], 4'hF);
        check("t1_w1_addr", log_addr[1], BASE + 32'd4);
        check("t1_w1_data", log_data[1], 32'h0807_0605);
        check("t1_w1_be", log_be[1], 4'hF);
        check("t1_byte_cnt", bus.byte_cnt_o, 16'd8);

        // five bytes, partial second word
        log_clear();
        begin_frame();
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
        end_frame();
        wait_done(++nd);
        check("t2_nwrites", log_addr.size(), 2);
        check("t2_w0_data", log_data[0], 32'hA3A2_A1A0);
        check("t2_w1_addr", log_addr[1], BASE + 32'd4);
        check("t2_w1_data", log_data[1], 32'h0000_00A4);
        check("t2_w1_be", log_be[1], 4'b0001);
        check("t2_byte_cnt", bus.byte_cnt_o, 16'd5);

        // grant held off for 6 cycles, stop arrives inside the stall
        log_clear();
        gnt_delay = 6;
        begin_frame();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        step(2);
        end_frame();
        wait_done(++nd);
        gnt_delay = 0;
        check("t3_stall_cycles", last_stall, 6);
        check("t3_done_after_gnt", done_cyc, gnt_cyc + 1);
        check("t3_w0_data", log_data[0], 32'h4433_2211);
        check("t3_byte_cnt", bus.byte_cnt_o, 16'd4);

        // ten bytes into an eight byte budget
        log_clear();
        begin_frame();
        for (int i = 0; i < 10; i++) send_byte(8'h30 + 8'(i));
        end_frame();
        wait_done(++nd);
        check("t4_nwrites", log_addr.size(), 2);
        check("t4_w1_data", log_data[1], 32'h3736_3534);
        check("t4_overflow", bus.overflow_o, 1'b1);
        check("t4_byte_cnt", bus.byte_cnt_o, 16'd8);

        // next start clears overflow; immediate stop writes nothing
        log_clear();
        begin_frame();
        check("t5_overflow_cleared", bus.overflow_o, 1'b0);
        check("t5_byte_cnt_cleared", bus.byte_cnt_o, 16'd0);
        end_frame();
        wait_done(++nd);
        check("t5_nwrites", log_addr.size(), 0);
        check("t5_byte_cnt", bus.byte_cnt_o, 16'd0);

        // repeated start after two bytes, then a full word
        log_clear();
        begin_frame();
        send_byte(8'h55);
        send_byte(8'h66);
        model_end();
        model_start();
        pulse_start();
        send_byte(8'hC1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        send_byte(8'hC4);
        end_frame();
        nd += 2;
        wait_done(nd);
        check("t6_nwrites", log_addr.size(), 2);
        check("t6_w0_addr", log_addr[0], BASE);
        check("t6_w0_data", log_data[0], 32'h0000_6655);
        check("t6_w0_be", log_be[0], 4'b0011);
        check("t6_w1_addr", log_addr[1], BASE);
        check("t6_w1_data", log_data[1], 32'hC4C3_C2C1);
        check("t6_byte_cnt", bus.byte_cnt_o, 16'd4);

        // reset while a write is stalled
        log_clear();
        gnt_delay = 50;
        begin_frame();
        for (int i = 0; i < 4; i++) send_byte(8'h90 + 8'(i));
        step(2);
        check("t7_in_write", bus.mem_req_o, 1'b1);
        done_before = dut_done;
        rst = 1'b1;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_be_q.delete();
        done_cnt_q.delete();
        done_ovf_q.delete();
        step();
        check_zero("t7");
        rst = 1'b0;
        gnt_delay = 0;
        step(6);
        check("t7_no_done", dut_done, done_before);
        check("t7_no_write", log_addr.size(), 0);

        check("end_writes_drained", exp_addr_q.size(), 0);
        check("end_dones_drained", done_cnt_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
